module_rx_uart: RTL and testbench

Receive-side UART peripheral: the counterpart of the UART transmit peripheral on the same processor bus. It samples the serial line, deserialises 8N1 frames (LSB first), and exposes a control/status register and a data register to the processor through the same two-register map as the transmit side. Address bit 2 selects the register: 0 is control, 1 is data. It sits beside the TX peripheral under the system top and drives the processor read-data mux.

---
 rtl/module_rx_uart.sv | 102 ++++++++++
 tb/tb_module_rx_uart.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/module_rx_uart.sv
// module_rx_uart: 8N1 UART receiver exposing a control/status register and a data register on the processor bus
// Ports: clk_i clock; rst_i synchronous active-low reset; rx_i asynchronous serial line (idle high);
//        we_proc_i/addr_proc_i/do_proc_i processor write (addr bit 2: 0 = control, 1 = data);
//        do_proc_o combinational read data; rx_done_o one-cycle pulse per committed byte
module module_rx_uart #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        we_proc_i,
  input  logic [31:0] addr_proc_i,
  input  logic [31:0] do_proc_i,
  output logic [31:0] do_proc_o,
  output logic        rx_done_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_state;
  logic r_sync1, r_sync2, r_prev;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0] r_bit, w_bit;
  logic [7:0] r_shift, w_shift, r_data;
  logic r_new, r_ovr, r_ferr, r_done;
  logic w_fall, w_commit, w_ferr_set, w_wr_ctrl;
  logic w_new, w_ovr, w_ferr, w_unused;
  assign w_fall = r_prev & ~r_sync2;
  assign w_wr_ctrl = we_proc_i & ~addr_proc_i[2];
  // a hardware set in the same cycle as a processor clear wins
  assign w_new = w_commit | (r_new & ~(w_wr_ctrl & ~do_proc_i[0]));
  assign w_ovr = (w_commit & r_new) | (r_ovr & ~(w_wr_ctrl & ~do_proc_i[1]));
  assign w_ferr = w_ferr_set | (r_ferr & ~(w_wr_ctrl & ~do_proc_i[2]));
  assign do_proc_o = addr_proc_i[2] ? {24'b0, r_data} : {29'b0, r_ferr, r_ovr, r_new};
  assign rx_done_o = r_done;
  assign w_unused = ^{addr_proc_i[31:3], addr_proc_i[1:0], do_proc_i[31:3]};
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt + 1'b1;
    w_bit = r_bit;
    w_shift = r_shift;
    w_commit = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (w_fall) begin
          w_state = START;
          w_bit = '0;
        end
      end
      START: if (r_cnt == MID) begin
        w_cnt = '0;
        w_state = r_sync2 ? IDLE : DATA;
      end
      DATA: if (r_cnt == LAST) begin
        w_cnt = '0;
        w_shift[r_bit] = r_sync2;
        w_bit = r_bit + 1'b1;
        w_state = (r_bit == 3'd7) ? STOP : DATA;
      end
      STOP: if (r_cnt == LAST) begin
        // leaves at mid stop bit so a directly following start edge is caught
        w_cnt = '0;
        w_state = IDLE;
        w_commit = r_sync2;
        w_ferr_set = ~r_sync2;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev <= 1'b1;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_data <= '0;
      r_new <= 1'b0;
      r_ovr <= 1'b0;
      r_ferr <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_prev <= r_sync2;
      r_cnt <= w_cnt;
      r_bit <= w_bit;
      r_shift <= w_shift;
      r_data <= w_commit ? r_shift : r_data;
      r_new <= w_new;
      r_ovr <= w_ovr;
      r_ferr <= w_ferr;
      r_done <= w_commit;
    end
  end
endmodule

// File: tb/tb_module_rx_uart.sv
// tb_module_rx_uart: randomized and directed scoreboard bench for module_rx_uart
module tb_module_rx_uart;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst_i, rx_i, we_proc_i, rx_done_o;
  logic [31:0] addr_proc_i, do_proc_i, do_proc_o;
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  logic m_new, m_ovr, m_ferr;
  logic [7:0] m_data;
  always #5 clk = ~clk;
  module_rx_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .we_proc_i(we_proc_i),
    .addr_proc_i(addr_proc_i), .do_proc_i(do_proc_i), .do_proc_o(do_proc_o), .rx_done_o(rx_done_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) begin
    if (rx_done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: rx_done_o=1 with no frame pending at %0t", $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (addr_proc_i[2]) chk("pulse_data", do_proc_o, {24'b0, e});
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic track);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (track) begin
      if (stop) begin
        m_ovr = m_ovr | m_new;
        m_new = 1'b1;
        m_data = b;
        exp_q.push_back(b);
      end else m_ferr = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_i = 1'b1;
  endtask
  task automatic wr(input logic a, input logic [31:0] v);
    we_proc_i = 1'b1;
    addr_proc_i = a ? 32'h4 : 32'h0;
    do_proc_i = v;
    @(posedge clk);
    #1;
    we_proc_i = 1'b0;
    addr_proc_i = 32'h4;
    if (!a) begin
      m_new = m_new & v[0];
      m_ovr = m_ovr & v[1];
      m_ferr = m_ferr & v[2];
    end
  endtask
  task automatic check_regs(input string tag);
    logic [31:0] c, d;
    addr_proc_i = 32'h0;
    #1 c = do_proc_o;
    addr_proc_i = 32'h4;
    #1 d = do_proc_o;
    chk({tag, "_ctrl"}, c, {29'b0, m_ferr, m_ovr, m_new});
    chk({tag, "_data"}, d, {24'b0, m_data});
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_i = 1'b0;
    rx_i = 1'b1;
    we_proc_i = 1'b0;
    addr_proc_i = 32'h4;
    do_proc_i = 32'h0;
    {m_new, m_ovr, m_ferr, m_data} = '0;
    idle(2);
    check_regs("reset");
    chk("reset_done", {31'b0, rx_done_o}, 32'h0);
    rst_i = 1'b1;
    idle(3);
    send(8'hA5, 1'b1, 1'b1);
    check_regs("single");
    wr(1'b0, 32'h0);
    check_regs("single_clr");
    send(8'h3C, 1'b1, 1'b1);
    send(8'hC3, 1'b1, 1'b1);
    check_regs("overrun");
    wr(1'b0, 32'h2);
    check_regs("overrun_clr");
    wr(1'b0, 32'h0);
    send(8'h55, 1'b0, 1'b1);
    idle(4);
    check_regs("frame_err");
    send(8'h81, 1'b1, 1'b1);
    check_regs("after_ferr");
    wr(1'b0, 32'h0);
    rx_i = 1'b0;
    idle(5);
    rx_i = 1'b1;
    idle(20);
    check_regs("glitch");
    send(8'h0F, 1'b1, 1'b1);
    check_regs("after_glitch");
    fork
      send(8'hFF, 1'b1, 1'b0);
      begin
        idle(88);
        rst_i = 1'b0;
        idle(1);
        rst_i = 1'b1;
        {m_new, m_ovr, m_ferr, m_data} = '0;
        check_regs("mid_reset");
        chk("mid_reset_done", {31'b0, rx_done_o}, 32'h0);
      end
    join
    idle(3);
    check_regs("after_reset_idle");
    send(8'h12, 1'b1, 1'b1);
    check_regs("after_reset");
    wr(1'b0, 32'h0);
    fork
      send(8'h99, 1'b1, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        we_proc_i = 1'b1;
        addr_proc_i = 32'h0;
        do_proc_i = 32'h0;
        @(posedge clk);
        #1;
        we_proc_i = 1'b0;
        addr_proc_i = 32'h4;
      end
    join
    check_regs("collision");
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      logic ok;
      int gap;
      b = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      gap = ok ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 8));
      send(b, ok, 1'b1);
      check_regs("rand");
      if ($urandom_range(0, 2) == 0) begin
        wr(1'($urandom_range(0, 1)), $urandom);
        check_regs("rand_wr");
      end
      idle(gap);
    end
    idle(5);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
